// File: rtl/mux4_rr_scheduler_pkg.sv
// Shared types and helpers for the 4-way round-robin mux scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mux4_rr_scheduler_pkg;

  localparam int N_REQ = 4;

  // Scheduler phases; the unused code 2'd3 is treated as IDLE by the top.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // One-hot grant vector for a binary owner index.
  function automatic logic [N_REQ-1:0] onehot4(input logic [1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux4_rr_scheduler_rr_pick4.sv
// Rotate-priority picker: first requester after 'last', wrapping, 'last' itself checked last.
// Latency: combinational.
// Backpressure: none; any=0 when no request is present.
// Ports: req[3:0] requests, last[1:0] previous owner -> any (some request), idx[1:0] winner.
module rr_pick4
  import mux4_rr_scheduler_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       last,
  output logic             any,
  output logic [1:0]       idx
);

  // Walk from lowest priority (last+4 == last) up to highest (last+1) so the
  // final assignment that fires is the highest-priority requester.
  always_comb begin
    any = 1'b0;
    idx = 2'd0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[last + 2'(k)]) begin
        any = 1'b1;
        idx = last + 2'(k);
      end
    end
  end

endmodule

// File: rtl/mux4_rr_scheduler.sv
// Round-robin owner scheduler driving sel/en of a shared 4:1 enabled mux.
// Latency: 1 cycle from request to grant; >=GAP_CYC en=0 cycles between different owners.
// Backpressure: owner held while req[owner]=1, preempted after MAX_BURST cycles only if others wait.
// Ports: clk, rst_n (async low), req[3:0] in; gnt[3:0] one-hot, sel[1:0], en, busy out (all registered).
module mux4_rr_scheduler
  import mux4_rr_scheduler_pkg::*;
#(
  parameter int MAX_BURST = 8,
  parameter int BURST_W   = 4,
  parameter int GAP_CYC   = 1,
  parameter int GAP_W     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [1:0]       sel,
  output logic             en,
  output logic             busy
);

  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_CYC - 1);

  state_t             r_state;
  logic [1:0]         r_last;
  logic [BURST_W-1:0] r_burst;
  logic [GAP_W-1:0]   r_gap;
  logic [N_REQ-1:0]   r_gnt;
  logic [1:0]         r_sel;
  logic               r_en;
  logic               r_busy;

  logic               w_any;
  logic [1:0]         w_idx;
  logic               w_owner_req;
  logic               w_others;
  logic               w_expire;
  logic               w_release;

  rr_pick4 u_pick (
    .req  (req),
    .last (r_last),
    .any  (w_any),
    .idx  (w_idx)
  );

  // r_sel doubles as the owner index while in GRANT.
  assign w_owner_req = req[r_sel];
  assign w_others    = |(req & ~onehot4(r_sel));
  assign w_expire    = (r_burst == BURST_LAST);
  // A drop coinciding with expiry is still a single release.
  assign w_release   = !w_owner_req || (w_expire && w_others);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_last  <= 2'd3;
      r_burst <= '0;
      r_gap   <= '0;
      r_gnt   <= '0;
      r_sel   <= 2'd0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_GRANT;
            r_gnt   <= onehot4(w_idx);
            r_sel   <= w_idx;
            r_en    <= 1'b1;
            r_busy  <= 1'b1;
            r_burst <= '0;
          end
        end
        ST_GRANT: begin
          if (w_release) begin
            r_state <= ST_GAP;
            r_gnt   <= '0;
            r_en    <= 1'b0;
            r_last  <= r_sel;
            r_burst <= '0;
            r_gap   <= '0;
          end else if (w_expire) begin
            // Lone requester: restart the burst without a dead cycle.
            r_burst <= '0;
          end else begin
            r_burst <= r_burst + 1'b1;
          end
        end
        ST_GAP: begin
          if (r_gap == GAP_LAST) begin
            if (w_any) begin
              r_state <= ST_GRANT;
              r_gnt   <= onehot4(w_idx);
              r_sel   <= w_idx;
              r_en    <= 1'b1;
              r_burst <= '0;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
          r_en    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt  = r_gnt;
  assign sel  = r_sel;
  assign en   = r_en;
  assign busy = r_busy;

endmodule

// File: tb/tb_mux4_rr_scheduler.sv
// Self-checking bench for mux4_rr_scheduler: directed scenarios plus random request traffic
// compared every cycle against a behavioural owner/hold-count/gap-count model.
module tb_mux4_rr_scheduler;

  localparam int MAX_BURST = 8;
  localparam int GAP_CYC   = 1;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req   = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       en;
  logic       busy;

  mux4_rr_scheduler #(
    .MAX_BURST (MAX_BURST),
    .BURST_W   (4),
    .GAP_CYC   (GAP_CYC),
    .GAP_W     (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt),
    .sel   (sel),
    .en    (en),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: owner (-1 = none), cycles held in current burst,
  // dead cycles still to go, previous owner, displayed select.
  int m_owner, m_held, m_gap, m_last, m_sel;
  // Owner-change tracker over observed outputs.
  int t_prev, t_zeros;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (last + k) % 4;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_held = 0; m_gap = 0; m_last = 3; m_sel = 0;
    t_prev  = -1; t_zeros = 0;
  endtask

  task automatic model_take(input logic [3:0] r);
    int w;
    w = pick(r, m_last);
    if (w >= 0) begin
      m_owner = w; m_held = 1; m_sel = w;
    end
  endtask

  task automatic model_step(input logic [3:0] r);
    if (m_owner >= 0) begin
      if (!r[m_owner] || (m_held == MAX_BURST && (r & ~(4'b0001 << m_owner)) != 4'b0000)) begin
        m_last  = m_owner;
        m_owner = -1;
        m_gap   = GAP_CYC;
      end else if (m_held == MAX_BURST) begin
        m_held = 1;
      end else begin
        m_held++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
      if (m_gap == 0) model_take(r);
    end else begin
      model_take(r);
    end
  endtask

  task automatic check_outputs();
    logic [3:0] e_gnt;
    int gi;
    e_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    chk("gnt", gnt, e_gnt);
    chk("sel", sel, m_sel);
    chk("en", en, m_owner >= 0);
    chk("busy", busy, (m_owner >= 0) || (m_gap > 0));
    chk("onehot0", $onehot0(gnt), 1);
    chk("en_vs_gnt", en, |gnt);
    if (en) begin
      gi = 0;
      for (int i = 0; i < 4; i++) if (gnt[i]) gi = i;
      chk("sel_idx", sel, gi);
      if (t_prev >= 0 && gi != t_prev) chk("gap_on_switch", t_zeros >= GAP_CYC, 1);
      t_prev  = gi;
      t_zeros = 0;
    end else begin
      t_zeros++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(req);
    #1;
    check_outputs();
  endtask

  // Called just after a sampled edge; pulls reset between edges.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_gnt", gnt, 0);
    chk("arst_en", en, 0);
    chk("arst_busy", busy, 0);
    chk("arst_sel", sel, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    logic [3:0] fexp;
    model_reset();

    // Reset held with all requests pending.
    #3 rst_n = 1'b0;
    req = 4'b1111;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;

    // Fairness: 8-cycle bursts, one dead cycle, owners 0,1,2,3,0.
    for (int t = 0; t < 44; t++) begin
      tick();
      fexp = (t % 9 == 8) ? 4'b0000 : (4'b0001 << ((t / 9) % 4));
      chk("fair_seq", gnt, fexp);
    end

    // Lone requester: never preempted, no gaps.
    req = 4'b0000;
    repeat (4) tick();
    req = 4'b0100;
    cnt = 0;
    repeat (30) begin
      tick();
      if (en && gnt == 4'b0100 && sel == 2'd2) cnt++;
    end
    chk("lone_en_cycles", cnt, 30);

    // Early drop of owner 1 with requester 3 waiting.
    async_reset();
    req = 4'b0010;
    tick();
    req = 4'b1010;
    tick();
    tick();
    req = 4'b1000;
    tick();
    chk("drop_gap_sel", sel, 1);
    chk("drop_gap_en", en, 0);
    tick();
    chk("drop_next_gnt", gnt, 4'b1000);
    chk("drop_next_sel", sel, 3);

    // Rotation skip: last=1, only req0 -> wraps to 0; then 0 expires into 1.
    req = 4'b0010;
    tick();
    tick();
    chk("skip_own1", gnt, 4'b0010);
    req = 4'b0001;
    tick();
    tick();
    chk("skip_wrap", gnt, 4'b0001);
    req = 4'b0011;
    repeat (9) tick();
    chk("skip_next", gnt, 4'b0010);

    // Async reset mid-grant, then restart at req0.
    async_reset();
    req = 4'b1111;
    tick();
    chk("restart_req0", gnt, 4'b0001);

    // Random traffic with occasional mid-cycle resets.
    repeat (1500) begin
      if ($urandom_range(0, 11) == 0) req = 4'($urandom_range(0, 15));
      tick();
      if ($urandom_range(0, 399) == 0) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
